// File: rtl/conv_row_mac_if.sv
// conv_row_mac_if
// Bundles the pixel stream, the weight-load bus and the run-time mode
// controls of one conv_row_mac instance.
//   master : drives ce, in_valid, row_start, din, psum_in, pad_en, sat_en,
//            w_we, w_addr, w_data; receives out_valid, dout
//   slave  : the engine side of the same signals
// Parameters must match those of the conv_row_mac instance it is bound to.
interface conv_row_mac_if #(
    parameter int DW   = 8,
    parameter int WW   = 8,
    parameter int TAPS = 3,
    parameter int OW   = 24
);
    localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1;

    logic                 ce;
    logic                 in_valid;
    logic                 row_start;
    logic signed [DW-1:0] din;
    logic signed [OW-1:0] psum_in;
    logic                 pad_en;
    logic                 sat_en;
    logic                 w_we;
    logic [AW-1:0]        w_addr;
    logic signed [WW-1:0] w_data;
    logic                 out_valid;
    logic signed [OW-1:0] dout;

    modport master (
        output ce, in_valid, row_start, din, psum_in, pad_en, sat_en,
               w_we, w_addr, w_data,
        input  out_valid, dout
    );

    modport slave (
        input  ce, in_valid, row_start, din, psum_in, pad_en, sat_en,
               w_we, w_addr, w_data,
        output out_valid, dout
    );
endinterface

// File: rtl/conv_row_mac.sv
// conv_row_mac
// 1-D convolution row engine: TAPS-deep signed sliding window, per-tap signed
// weights (shadow/active banks), partial-sum input, optional zero padding and
// saturation. Three ce-gated stages: window (E0), products (E1),
// reduction + formatting (E2).
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : conv_row_mac_if.slave (stream in/out, weight bus, mode controls)
module conv_row_mac #(
    parameter int DW   = 8,
    parameter int WW   = 8,
    parameter int TAPS = 3,
    parameter int OW   = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    conv_row_mac_if.slave bus
);
    localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int FW = $clog2(TAPS + 1);
    localparam int PW = DW + WW;
    localparam int SW = DW + WW + $clog2(TAPS) + 1;
    localparam int IW = ((SW > OW) ? SW : OW) + 1;

    localparam logic signed [IW-1:0] SAT_MAX = {{(IW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [IW-1:0] SAT_MIN = {{(IW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    // E0: window and per-pixel flags
    logic signed [DW-1:0] x_reg [TAPS];
    logic [FW-1:0]        fill_reg;
    logic                 v0_reg;
    logic                 sat0_reg;
    logic signed [OW-1:0] psum0_reg;

    // weight banks
    logic signed [WW-1:0] shadow_reg [TAPS];
    logic signed [WW-1:0] active_reg [TAPS];

    // E1: products
    logic signed [PW-1:0] prod_next [TAPS];
    logic signed [PW-1:0] prod_reg  [TAPS];
    logic                 v1_reg;
    logic                 sat1_reg;
    logic signed [OW-1:0] psum1_reg;

    // E2: result
    logic                 out_valid_reg;
    logic signed [OW-1:0] dout_reg;

    logic                 accept;
    logic [FW-1:0]        fill_next;
    logic                 qual_next;
    logic signed [IW-1:0] sum_full;
    logic signed [OW-1:0] result;

    assign accept = bus.in_valid & bus.ce;

    // Fill count after this accept; row_start counts the new pixel as the
    // first of the row.
    always_comb begin
        fill_next = fill_reg;
        if (bus.row_start) begin
            fill_next = FW'(1);
        end else if (fill_reg < FW'(TAPS)) begin
            fill_next = fill_reg + FW'(1);
        end
        qual_next = bus.pad_en | (fill_next >= FW'(TAPS));
    end

    // Window. On row_start the whole history behind the new pixel becomes
    // zero, so padded outputs never see the previous row's pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) begin
                x_reg[k] <= '0;
            end
            fill_reg  <= '0;
            v0_reg    <= 1'b0;
            sat0_reg  <= 1'b0;
            psum0_reg <= '0;
        end else if (bus.ce) begin
            v0_reg <= accept & qual_next;
            if (accept) begin
                x_reg[0] <= bus.din;
                for (int k = 1; k < TAPS; k++) begin
                    x_reg[k] <= bus.row_start ? '0 : x_reg[k-1];
                end
                fill_reg  <= fill_next;
                sat0_reg  <= bus.sat_en;
                psum0_reg <= bus.psum_in;
            end
        end
    end

    // Weight banks. Writes ignore ce. The row_start copy reads the shadow
    // value from before any same-cycle write, which therefore lands only in
    // shadow for the following row. Addresses >= TAPS match no entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) begin
                shadow_reg[k] <= '0;
                active_reg[k] <= '0;
            end
        end else begin
            for (int k = 0; k < TAPS; k++) begin
                if (bus.w_we && (bus.w_addr == AW'(k))) begin
                    shadow_reg[k] <= bus.w_data;
                end
            end
            if (accept && bus.row_start) begin
                for (int k = 0; k < TAPS; k++) begin
                    active_reg[k] <= shadow_reg[k];
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < TAPS; gi++) begin : g_prod
            assign prod_next[gi] = PW'(x_reg[gi]) * PW'(active_reg[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) begin
                prod_reg[k] <= '0;
            end
            v1_reg    <= 1'b0;
            sat1_reg  <= 1'b0;
            psum1_reg <= '0;
        end else if (bus.ce) begin
            for (int k = 0; k < TAPS; k++) begin
                prod_reg[k] <= prod_next[k];
            end
            v1_reg    <= v0_reg;
            sat1_reg  <= sat0_reg;
            psum1_reg <= psum0_reg;
        end
    end

    // Reduction is one bit wider than both the product sum and psum, so the
    // clamp decision is made on an exact value.
    always_comb begin
        sum_full = IW'(psum1_reg);
        for (int k = 0; k < TAPS; k++) begin
            sum_full = sum_full + IW'(prod_reg[k]);
        end
        result = sum_full[OW-1:0];
        if (sat1_reg) begin
            if (sum_full > SAT_MAX) begin
                result = SAT_MAX[OW-1:0];
            end else if (sum_full < SAT_MIN) begin
                result = SAT_MIN[OW-1:0];
            end
        end
    end

    // dout only moves on a valid result; bubbles leave it at its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            dout_reg      <= '0;
        end else if (bus.ce) begin
            out_valid_reg <= v1_reg;
            if (v1_reg) begin
                dout_reg <= result;
            end
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.dout      = dout_reg;
endmodule

// File: tb/tb_conv_row_mac.sv
// tb_conv_row_mac
// Directed bench for conv_row_mac: a 24-bit-output instance for the main
// scenarios and a 16-bit-output instance for saturation/wrap. Expected
// results are queued when a pixel is driven and compared as the DUT emits.
module tb_conv_row_mac;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int total = 0;
    int bad   = 0;

    longint q24[$];
    longint q16[$];

    always #5 clk = ~clk;

    conv_row_mac_if #(.DW(8), .WW(8), .TAPS(3), .OW(24)) b24 ();
    conv_row_mac_if #(.DW(8), .WW(8), .TAPS(3), .OW(16)) b16 ();

    conv_row_mac #(.DW(8), .WW(8), .TAPS(3), .OW(24)) u24 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b24)
    );

    conv_row_mac #(.DW(8), .WW(8), .TAPS(3), .OW(16)) u16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b16)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic px24(input int d, input bit rs, input int ps, input bit push, input longint e);
        b24.in_valid  = 1'b1;
        b24.row_start = rs;
        b24.din       = 8'(d);
        b24.psum_in   = 24'(ps);
        if (push) q24.push_back(e);
        tick();
        $display("u24 pixel din=%0d row_start=%0d psum=%0d pad=%0d ce=%0d", d, rs, ps, b24.pad_en, b24.ce);
        b24.in_valid  = 1'b0;
        b24.row_start = 1'b0;
        b24.w_we      = 1'b0;
    endtask

    task automatic px16(input int d, input bit rs, input bit sat, input bit push, input longint e);
        b16.in_valid  = 1'b1;
        b16.row_start = rs;
        b16.din       = 8'(d);
        b16.sat_en    = sat;
        if (push) q16.push_back(e);
        tick();
        $display("u16 pixel din=%0d row_start=%0d sat=%0d", d, rs, sat);
        b16.in_valid  = 1'b0;
        b16.row_start = 1'b0;
    endtask

    task automatic wr24(input int a, input int d);
        b24.w_we   = 1'b1;
        b24.w_addr = 2'(a);
        b24.w_data = 8'(d);
        tick();
        $display("u24 weight write addr=%0d data=%0d", a, d);
        b24.w_we   = 1'b0;
    endtask

    task automatic wr16(input int a, input int d);
        b16.w_we   = 1'b1;
        b16.w_addr = 2'(a);
        b16.w_data = 8'(d);
        tick();
        $display("u16 weight write addr=%0d data=%0d", a, d);
        b16.w_we   = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (q24.size() == 0 && q16.size() == 0) break;
            tick();
        end
        check("drain_left", longint'(q24.size() + q16.size()), 0);
        repeat (4) tick();
    endtask

    // Output consumption happens on out_valid & ce at the next rising edge;
    // inputs change just after rising edges, so the negedge sees both.
    always @(negedge clk) begin
        if (rst_n && b24.ce && b24.out_valid) begin
            check("u24_pending", longint'(q24.size() > 0), 1);
            if (q24.size() > 0) begin
                longint e24;
                e24 = q24.pop_front();
                $display("u24 out dout=%0d expected=%0d", longint'(b24.dout), e24);
                check("u24_dout", longint'(b24.dout), e24);
            end
        end
        if (rst_n && b16.ce && b16.out_valid) begin
            check("u16_pending", longint'(q16.size() > 0), 1);
            if (q16.size() > 0) begin
                longint e16;
                e16 = q16.pop_front();
                $display("u16 out dout=%0d expected=%0d", longint'(b16.dout), e16);
                check("u16_dout", longint'(b16.dout), e16);
            end
        end
    end

    initial begin
        b24.ce = 1'b1; b24.in_valid = 1'b0; b24.row_start = 1'b0; b24.din = '0;
        b24.psum_in = '0; b24.pad_en = 1'b0; b24.sat_en = 1'b0;
        b24.w_we = 1'b0; b24.w_addr = '0; b24.w_data = '0;
        b16.ce = 1'b1; b16.in_valid = 1'b0; b16.row_start = 1'b0; b16.din = '0;
        b16.psum_in = '0; b16.pad_en = 1'b0; b16.sat_en = 1'b1;
        b16.w_we = 1'b0; b16.w_addr = '0; b16.w_data = '0;

        // reset state
        tick();
        tick();
        check("rst_u24_valid", longint'(b24.out_valid), 0);
        check("rst_u24_dout",  longint'(b24.dout), 0);
        check("rst_u16_valid", longint'(b16.out_valid), 0);
        check("rst_u16_dout",  longint'(b16.dout), 0);
        rst_n = 1'b1;
        tick();

        // 1: valid-only window, weights 1,2,3 -> 10, 16, latency 3 edges
        wr24(0, 1);
        wr24(1, 2);
        wr24(2, 3);
        px24(1, 1, 0, 0, 0);
        px24(2, 0, 0, 0, 0);
        px24(3, 0, 0, 1, 10);
        check("t1_lat_edge1", longint'(b24.out_valid), 0);
        px24(4, 0, 0, 1, 16);
        check("t1_lat_edge2", longint'(b24.out_valid), 0);
        tick();
        check("t1_lat_edge3_valid", longint'(b24.out_valid), 1);
        check("t1_lat_edge3_dout",  longint'(b24.dout), 10);
        drain();

        // 2: padded window -> 1, 4, 10, 16
        b24.pad_en = 1'b1;
        px24(1, 1, 0, 1, 1);
        px24(2, 0, 0, 1, 4);
        px24(3, 0, 0, 1, 10);
        px24(4, 0, 0, 1, 16);
        check("t2_b2b_valid", longint'(b24.out_valid), 1);
        check("t2_b2b_dout",  longint'(b24.dout), 4);
        drain();
        b24.pad_en = 1'b0;

        // 3: psum_in = -5 -> 5, 11
        px24(1, 1, -5, 0, 0);
        px24(2, 0, -5, 0, 0);
        px24(3, 0, -5, 1, 5);
        px24(4, 0, -5, 1, 11);
        drain();

        // 4: OW=16, all -128: sat -> 32767, wrap -> -16384
        wr16(0, -128);
        wr16(1, -128);
        wr16(2, -128);
        px16(-128, 1, 1, 0, 0);
        px16(-128, 0, 1, 0, 0);
        px16(-128, 0, 1, 1, 32767);
        px16(-128, 0, 0, 1, -16384);
        drain();

        // 5: shadow writes during row 1; write on row-2 start lands for row 3
        px24(1, 1, 0, 0, 0);
        b24.w_we = 1'b1; b24.w_addr = 2'd1; b24.w_data = 8'sd1;
        px24(2, 0, 0, 0, 0);
        b24.w_we = 1'b1; b24.w_addr = 2'd0; b24.w_data = 8'sd1;
        px24(3, 0, 0, 1, 10);
        px24(4, 0, 0, 1, 16);
        drain();
        b24.w_we = 1'b1; b24.w_addr = 2'd2; b24.w_data = 8'sd1;
        px24(1, 1, 0, 0, 0);
        b24.w_we = 1'b1; b24.w_addr = 2'd3; b24.w_data = 8'sd50;
        px24(2, 0, 0, 0, 0);
        px24(3, 0, 0, 1, 8);
        px24(4, 0, 0, 1, 13);
        drain();
        px24(1, 1, 0, 0, 0);
        px24(2, 0, 0, 0, 0);
        px24(3, 0, 0, 1, 6);
        px24(4, 0, 0, 1, 9);
        drain();

        // 6a: ce stall with a result on the output
        px24(1, 1, 0, 0, 0);
        px24(2, 0, 0, 0, 0);
        px24(3, 0, 0, 1, 6);
        px24(4, 0, 0, 1, 9);
        px24(5, 0, 0, 1, 12);
        b24.ce = 1'b0;
        check("t6_pre_stall_valid", longint'(b24.out_valid), 1);
        check("t6_pre_stall_dout",  longint'(b24.dout), 6);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("t6_stall_valid", longint'(b24.out_valid), 1);
            check("t6_stall_dout",  longint'(b24.dout), 6);
        end
        b24.ce = 1'b1;
        px24(6, 0, 0, 1, 15);
        drain();

        // 6b: reset with two padded results in flight
        b24.pad_en = 1'b1;
        px24(1, 1, 0, 0, 0);
        px24(2, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", longint'(b24.out_valid), 0);
        check("t6_rst_dout",  longint'(b24.dout), 0);
        tick();
        rst_n = 1'b1;
        b24.pad_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t6_post_rst_valid", longint'(b24.out_valid), 0);
            check("t6_post_rst_dout",  longint'(b24.dout), 0);
        end
        // no row_start: fill must restart from 0 and active weights are 0
        px24(5, 0, 100, 0, 0);
        check("t6_fill_p1", longint'(b24.out_valid), 0);
        px24(6, 0, 100, 0, 0);
        check("t6_fill_p2", longint'(b24.out_valid), 0);
        px24(7, 0, 100, 1, 100);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
